// File: rtl/seg_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_pkg
// Shared definitions for the multiplexed 7-segment scan controller:
//   - state_t       : scan state machine encoding (blank gap / digit on)
//   - DIG_ALL_OFF   : all-digits-disabled pattern for the active-low enables,
//                     wide enough for any supported digit count
//   - cnt_width()   : width of the per-slot cycle counter
// -----------------------------------------------------------------------------
package seg_scan_ctrl_pkg;

  typedef enum logic {
    S_GAP = 1'b0,  // all digits off while the segment bus settles
    S_ON  = 1'b1   // current digit enabled (unless leading-zero blanked)
  } state_t;

  localparam int MAX_NDIG = 32;

  // Active-low enables: every bit high means no digit is driven.
  localparam logic [MAX_NDIG-1:0] DIG_ALL_OFF = '1;

  // Bits needed to count 0 .. scan_div-1; never narrower than one bit.
  function automatic int cnt_width(input int scan_div);
    return (scan_div > 1) ? $clog2(scan_div) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_seg.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_seg
// Hexadecimal 7-segment decoder, active-high segments (1 = segment lit).
// Ports:
//   bcd [3:0]  nibble to display; codes 10..15 show A b C d E F
//   dp         decimal point request, passed to seg[7]
//   seg [7:0]  {dp, g, f, e, d, c, b, a}
// -----------------------------------------------------------------------------
module seg_scan_ctrl_seg (
  input  logic [3:0] bcd,
  input  logic       dp,
  output logic [7:0] seg
);

  // NOTE: always_comb assigns a default before the case so every path drives
  // every bit; an incomplete assignment here would infer a latch.
  always_comb begin
    seg = {dp, 7'h00};
    case (bcd)
      4'h0: seg[6:0] = 7'h3F;
      4'h1: seg[6:0] = 7'h06;
      4'h2: seg[6:0] = 7'h5B;
      4'h3: seg[6:0] = 7'h4F;
      4'h4: seg[6:0] = 7'h66;
      4'h5: seg[6:0] = 7'h6D;
      4'h6: seg[6:0] = 7'h7D;
      4'h7: seg[6:0] = 7'h07;
      4'h8: seg[6:0] = 7'h7F;
      4'h9: seg[6:0] = 7'h6F;
      4'hA: seg[6:0] = 7'h77;
      4'hB: seg[6:0] = 7'h7C;
      4'hC: seg[6:0] = 7'h39;
      4'hD: seg[6:0] = 7'h5E;
      4'hE: seg[6:0] = 7'h79;
      4'hF: seg[6:0] = 7'h71;
      default: seg[6:0] = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for NDIG 7-segment digits sharing one
// segment bus. A producer writes a BCD value through a valid/ready port into
// a pending buffer; the value moves to the displayed (active) register at the
// end of a frame. Each digit slot is SCAN_DIV cycles: BLANK_GAP cycles with
// every digit off, then the digit is enabled. Optional leading-zero blanking.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   wr_valid    producer presents a new display value
//   wr_ready    pending buffer empty (registered)
//   wr_bcd      BCD nibbles, digit i at [4i+3:4i], digit 0 least significant
//   wr_dp       decimal point per digit, 1 = lit
//   blank_lz    leading-zero suppression enable (sampled live)
//   seg_out     [6:0] decoded segments of the current digit, [7] its dp
//   dig_sel_n   active-low digit enables, at most one low (registered)
//   frame_done  one-cycle pulse on the last cycle of each frame (registered)
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [4*NDIG-1:0] wr_bcd,
  input  logic [NDIG-1:0]   wr_dp,
  input  logic              blank_lz,
  output logic [7:0]        seg_out,
  output logic [NDIG-1:0]   dig_sel_n,
  output logic              frame_done
);

  localparam int CW = cnt_width(SCAN_DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [NDIG-1:0] DIG_OFF     = DIG_ALL_OFF[NDIG-1:0];
  localparam logic [CW-1:0]   CNT_GAP_END = CW'(BLANK_GAP - 1);
  localparam logic [CW-1:0]   CNT_END     = CW'(SCAN_DIV - 1);
  // frame_done is registered, so it is raised one cycle before the last one.
  localparam logic [CW-1:0]   CNT_FD      = CW'(SCAN_DIV - 2);
  localparam logic [IW-1:0]   LAST_IDX    = IW'(NDIG - 1);

  state_t            state;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     cnt;

  logic [4*NDIG-1:0] active_bcd;
  logic [NDIG-1:0]   active_dp;
  logic [4*NDIG-1:0] pend_bcd;
  logic [NDIG-1:0]   pend_dp;

  logic [NDIG-1:0]   blanked;
  logic              upper_zero;
  logic [NDIG-1:0]   on_sel;
  logic [3:0]        cur_nib;
  logic              cur_dp;

  // ---------------------------------------------------------------------------
  // Leading-zero mask: digit i (i > 0) is blanked when it and every higher
  // digit are zero. Codes 10..15 are non-zero and stop the run. Digit 0 is
  // never blanked so a value of zero still shows a single 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    upper_zero = 1'b1;
    blanked    = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (active_bcd[4*i +: 4] == 4'd0);
      blanked[i] = blank_lz && upper_zero;
    end
  end

  // Enable pattern for the current slot while in S_ON.
  always_comb begin
    on_sel = DIG_OFF;
    if (!blanked[idx]) on_sel[idx] = 1'b0;
  end

  // Segment bus follows idx during the gap too, so it settles before enable.
  // The dp of a blanked digit is suppressed along with the digit.
  assign cur_nib = active_bcd[4*idx +: 4];
  assign cur_dp  = active_dp[idx] & ~blanked[idx];

  seg_scan_ctrl_seg u_seg (
    .bcd (cur_nib),
    .dp  (cur_dp),
    .seg (seg_out)
  );

  // ---------------------------------------------------------------------------
  // Scan state machine. cnt runs 0..SCAN_DIV-1 across the whole slot; the gap
  // occupies the first BLANK_GAP counts. dig_sel_n is computed one cycle ahead
  // so it changes exactly at the slot/gap boundaries.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_GAP;
      idx        <= '0;
      cnt        <= '0;
      dig_sel_n  <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (cnt == CNT_FD) && (idx == LAST_IDX);
      case (state)
        S_GAP: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_GAP_END) begin
            state     <= S_ON;
            dig_sel_n <= on_sel;
          end
        end
        S_ON: begin
          if (cnt == CNT_END) begin
            cnt       <= '0;
            state     <= S_GAP;
            dig_sel_n <= DIG_OFF;
            idx       <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          end else begin
            cnt       <= cnt + 1'b1;
            dig_sel_n <= on_sel;
          end
        end
        default: begin
          state     <= S_GAP;
          dig_sel_n <= DIG_OFF;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Double buffer. The transfer slot (frame_done high, pending full) and the
  // accept slot (wr_ready high) are mutually exclusive because wr_ready is
  // simply "pending empty", so an accepted write is never lost.
  // ---------------------------------------------------------------------------
  // NOTE: the buffers are reset, not left uninitialised: reset must blank the
  // display to zero and discard any value still waiting in pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_bcd <= '0;
      active_dp  <= '0;
      pend_bcd   <= '0;
      pend_dp    <= '0;
      wr_ready   <= 1'b1;
    end else if (frame_done && !wr_ready) begin
      active_bcd <= pend_bcd;
      active_dp  <= pend_dp;
      pend_bcd   <= '0;
      pend_dp    <= '0;
      wr_ready   <= 1'b1;
    end else if (wr_valid && wr_ready) begin
      pend_bcd   <= wr_bcd;
      pend_dp    <= wr_dp;
      wr_ready   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl with NDIG=4, SCAN_DIV=8, BLANK_GAP=2.
// The reference derives every expected output from the cycle number since
// reset release (slot = cycle / SCAN_DIV, position = cycle % SCAN_DIV) plus a
// two-register model of the display/pending buffers.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int SD    = 8;
  localparam int BG    = 2;
  localparam int FRAME = NDIG * SD;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [4*NDIG-1:0] wr_bcd = '0;
  logic [NDIG-1:0]   wr_dp = '0;
  logic              blank_lz = 1'b0;
  logic [7:0]        seg_out;
  logic [NDIG-1:0]   dig_sel_n;
  logic              frame_done;

  seg_scan_ctrl #(
    .NDIG      (NDIG),
    .SCAN_DIV  (SD),
    .BLANK_GAP (BG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_bcd     (wr_bcd),
    .wr_dp      (wr_dp),
    .blank_lz   (blank_lz),
    .seg_out    (seg_out),
    .dig_sel_n  (dig_sel_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference segment patterns {g,f,e,d,c,b,a} for codes 0..F.
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int acc_cyc = -1;

  // Reference state: displayed value, pending value, pending-full flag, and
  // the previous cycle's blank_lz (enables are registered, so they reflect it).
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  bit          m_full;
  logic        m_prev_bl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit m_blank(input int i, input logic [15:0] act, input logic bl);
    return bl && (i > 0) && ((act >> (4 * i)) == 16'd0);
  endfunction

  task automatic model_reset();
    m_act     = '0;
    m_act_dp  = '0;
    m_pend    = '0;
    m_pend_dp = '0;
    m_full    = 1'b0;
    m_prev_bl = blank_lz;
    cyc       = 0;
  endtask

  // Called just after a rising edge: checks the current cycle at the falling
  // edge, advances the model across the next rising edge.
  task automatic tick();
    int          pos, idx;
    logic [3:0]  exp_dig;
    logic [7:0]  exp_seg;
    logic        exp_fd;
    @(negedge clk);
    pos     = cyc % SD;
    idx     = (cyc / SD) % NDIG;
    exp_dig = 4'hF;
    if (pos >= BG && !m_blank(idx, m_act, m_prev_bl)) exp_dig[idx] = 1'b0;
    exp_seg = {m_act_dp[idx] & !m_blank(idx, m_act, blank_lz), seg_tab[m_act[4*idx +: 4]]};
    exp_fd  = (cyc % FRAME) == FRAME - 1;
    check("dig_sel_n",  dig_sel_n,  exp_dig);
    check("seg_out",    seg_out,    exp_seg);
    check("frame_done", frame_done, exp_fd);
    check("wr_ready",   wr_ready,   !m_full);
    if (exp_fd && m_full) begin
      m_act    = m_pend;
      m_act_dp = m_pend_dp;
      m_full   = 1'b0;
    end else if (wr_valid && !m_full) begin
      m_pend    = wr_bcd;
      m_pend_dp = wr_dp;
      m_full    = 1'b1;
      acc_cyc   = cyc;
    end
    m_prev_bl = blank_lz;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // Producer: present a value and hold it until the model says it was taken.
  task automatic write_hold(input logic [15:0] v, input logic [3:0] dp);
    bit done = 1'b0;
    wr_valid = 1'b1;
    wr_bcd   = v;
    wr_dp    = dp;
    for (int k = 0; k < 4 * FRAME && !done; k++) begin
      done = !m_full;
      tick();
    end
    wr_valid = 1'b0;
    check("write_accepted", done, 1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wr_valid = 1'b0;
    @(negedge clk);
    check("rst_dig_sel_n",  dig_sel_n,  4'hF);
    check("rst_wr_ready",   wr_ready,   1);
    check("rst_frame_done", frame_done, 0);
    check("rst_seg_out",    seg_out,    {1'b0, seg_tab[0]});
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rv;

    // 1. Idle scan after reset: gap/on pattern, frame_done at cycle 31.
    do_reset();
    run_to(2 * FRAME + 4);

    // 2. Single write with dp on digit 1; shows from frame 1.
    do_reset();
    run_to(5);
    write_hold(16'h1234, 4'b0010);
    check("t2_accept_cycle", acc_cyc, 5);
    run_to(34);
    check("t2_dig0_on", dig_sel_n, 4'b1110);
    check("t2_seg_4",   seg_out,   {1'b0, seg_tab[4]});
    run_to(3 * FRAME);

    // 3. Second write held while pending is full; taken at cycle 32.
    do_reset();
    run_to(5);
    write_hold(16'h1234, 4'b0000);
    write_hold(16'h5678, 4'b1000);
    check("t3_accept_cycle", acc_cyc, 32);
    run_to(4 * FRAME + 8);

    // 4. Leading-zero blanking, including dp on blanked digits.
    blank_lz = 1'b1;
    do_reset();
    write_hold(16'h0007, 4'b1111);
    run_to(FRAME + SD + BG);
    check("t4_dig1_blank", dig_sel_n, 4'hF);
    run_to(2 * FRAME);
    write_hold(16'h0000, 4'b0001);
    run_to(4 * FRAME);
    write_hold(16'h1005, 4'b0000);
    run_to(6 * FRAME);
    blank_lz = 1'b0;

    // 5. Write on the frame_done cycle with pending empty.
    do_reset();
    run_to(FRAME - 1);
    write_hold(16'h9876, 4'b0101);
    check("t5_accept_cycle", acc_cyc, FRAME - 1);
    run_to(4 * FRAME);

    // 6. Asynchronous reset during digit 1's on-time with a pending value.
    do_reset();
    run_to(5);
    write_hold(16'h4321, 4'b1111);
    run_to(12);
    check("t6_pre_rst_dig", dig_sel_n, 4'b1101);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_dig",   dig_sel_n,  4'hF);
    check("t6_async_ready", wr_ready,   1);
    check("t6_async_fd",    frame_done, 0);
    check("t6_async_seg",   seg_out,    {1'b0, seg_tab[0]});
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run_to(2 * FRAME);

    // Randomized producer traffic with live blank_lz changes.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      blank_lz = 1'($urandom_range(0, 1));
      run_to(cyc + int'($urandom_range(0, 45)));
      rv = 16'($urandom >> (4 * $urandom_range(0, 4)));
      write_hold(rv, 4'($urandom));
    end
    run_to(cyc + 2 * FRAME);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
